// File: rtl/apb_mem_slave_if.sv
// APB3 bus bundle between an APB master (apb_converter or a bench) and apb_mem_slave.
// Optional APB_MEM_SLAVE_PSTRB_EN adds the PSTRB write-strobe lane enables.
interface apb_mem_slave_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_MEM_SLAVE_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
`ifdef APB_MEM_SLAVE_PSTRB_EN
        output PSTRB,
`endif
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
`ifdef APB_MEM_SLAVE_PSTRB_EN
        input  PSTRB,
`endif
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 slave backed by a byte-addressed memory array with programmable wait states.
// Misaligned or out-of-range accesses complete with PSLVERR=1, no write and PRDATA=0.
// Byte at address A+i lives on data lane [DATA_WIDTH-1-8*i -: 8] (lane 0 = MSB byte).
// Optional feature macro: APB_MEM_SLAVE_PSTRB_EN (adds PSTRB per-lane write enables).
// The bus interface instance must use the same ADDR_WIDTH/DATA_WIDTH as this module.
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_mem_slave_if.slave    bus
);

    localparam int          BYTES   = DATA_WIDTH / 8;
    localparam int          MEM_AW  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [31:0] BYTES_U = 32'(BYTES);
    localparam logic [31:0] MEM_U   = 32'(MEM_BYTES);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Error check on a byte address: misaligned or word runs past the end of memory.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] a32_s;
        a32_s = 32'(a);
        return ((a32_s % BYTES_U) != 32'd0) || ((a32_s + BYTES_U) > MEM_U);
    endfunction

    // Storage: intentionally not reset.
    logic [7:0]            mem_r [MEM_BYTES];

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nxt_s;
    logic                  latch_s;
    logic                  setup_s;
    logic                  complete_s;
    logic                  commit_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [BYTES-1:0]      wstrb_s;

    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic                  cur_write_s;
    logic                  err_cur_s;
    logic                  err_lat_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    logic [DATA_WIDTH-1:0] prdata_r;
    logic                  pready_r;
    logic                  pslverr_r;
    logic [DATA_WIDTH-1:0] prdata_nxt_s;
    logic                  pready_nxt_s;
    logic                  pslverr_nxt_s;

    assign setup_s    = bus.PSEL & ~bus.PENABLE;
    assign complete_s = (state_r == ST_READY) & bus.PSEL & bus.PENABLE;
    assign err_lat_s  = addr_err(addr_r);
    assign commit_s   = complete_s & write_r & ~err_lat_s;

    // Transfer attributes for the edge entering READY: bus values when latching now, else held copy.
    assign cur_addr_s  = latch_s ? bus.PADDR  : addr_r;
    assign cur_write_s = latch_s ? bus.PWRITE : write_r;
    assign err_cur_s   = addr_err(cur_addr_s);

`ifdef APB_MEM_SLAVE_PSTRB_EN
    logic [BYTES-1:0] strb_r;

    // Hold the write strobes of the transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            strb_r <= {BYTES{1'b0}};
        end else if (latch_s) begin
            strb_r <= bus.PSTRB;
        end
    end

    assign wstrb_s = strb_r;
`else
    assign wstrb_s = {BYTES{1'b1}};
`endif

    // FSM state and wait counter register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: setup detection, wait countdown, abort on PSEL drop, completion.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    latch_s     = 1'b1;
                    cnt_nxt_s   = WAIT_LD;
                    state_nxt_s = (WAIT_LD == 4'd0) ? ST_READY : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.PSEL) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_READY;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            ST_READY: begin
                // A setup phase sampled here starts the next transfer just as IDLE would.
                if (setup_s) begin
                    latch_s     = 1'b1;
                    cnt_nxt_s   = WAIT_LD;
                    state_nxt_s = (WAIT_LD == 4'd0) ? ST_READY : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Capture address, direction and write data at the setup phase.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            write_r <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (latch_s) begin
            addr_r  <= bus.PADDR;
            write_r <= bus.PWRITE;
            wdata_r <= bus.PWDATA;
        end
    end

    // Assemble the addressed word from memory bytes (lane 0 = lowest address = MSB).
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < BYTES; i++) begin
            rd_word_s[DATA_WIDTH-1-8*i -: 8] = mem_r[MEM_AW'(cur_addr_s) + MEM_AW'(i)];
        end
    end

    // Commit enabled byte lanes of an error-free write on its completion edge.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < BYTES; i++) begin
            if (commit_s && wstrb_s[i]) begin
                mem_r[MEM_AW'(addr_r) + MEM_AW'(i)] <= wdata_r[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    // Output decode: values the output registers take on the coming edge.
    always_comb begin
        pready_nxt_s  = (state_nxt_s == ST_READY);
        pslverr_nxt_s = 1'b0;
        prdata_nxt_s  = prdata_r;
        if (pready_nxt_s) begin
            pslverr_nxt_s = err_cur_s;
            if (err_cur_s) begin
                prdata_nxt_s = {DATA_WIDTH{1'b0}};
            end else if (!cur_write_s) begin
                prdata_nxt_s = rd_word_s;
            end else begin
                prdata_nxt_s = prdata_r;
            end
        end else begin
            pslverr_nxt_s = 1'b0;
            prdata_nxt_s  = prdata_r;
        end
    end

    // Registered bus outputs; async reset clears them immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prdata_r  <= {DATA_WIDTH{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            prdata_r  <= prdata_nxt_s;
            pready_r  <= pready_nxt_s;
            pslverr_r <= pslverr_nxt_s;
        end
    end

    assign bus.PRDATA  = prdata_r;
    assign bus.PREADY  = pready_r;
    assign bus.PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with 0 wait states, one with 3.
module tb_apb_mem_slave;

    logic        PCLK;
    logic        PRESETn;
    logic        psel0;
    logic        psel3;
    logic        penable;
    logic        pwrite;
    logic [12:0] paddr;
    logic [31:0] pwdata;
`ifdef APB_MEM_SLAVE_PSTRB_EN
    logic [3:0]  pstrb;
`endif

    int n_checks;
    int n_pass;

    logic [31:0] sweep_d [64];
    logic [31:0] rd_v;
    logic        err_v;
    int          waits_v;

    apb_mem_slave_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) if0 ();
    apb_mem_slave_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) if3 ();

    assign if0.PSEL    = psel0;
    assign if0.PENABLE = penable;
    assign if0.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;
    assign if3.PSEL    = psel3;
    assign if3.PENABLE = penable;
    assign if3.PWRITE  = pwrite;
    assign if3.PADDR   = paddr;
    assign if3.PWDATA  = pwdata;
`ifdef APB_MEM_SLAVE_PSTRB_EN
    assign if0.PSTRB   = pstrb;
    assign if3.PSTRB   = pstrb;
`endif

    apb_mem_slave #(
        .ADDR_WIDTH(13), .DATA_WIDTH(32), .MEM_BYTES(256), .WAIT_STATES(0)
    ) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(if0.slave)
    );

    apb_mem_slave #(
        .ADDR_WIDTH(13), .DATA_WIDTH(32), .MEM_BYTES(256), .WAIT_STATES(3)
    ) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(if3.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? if0.PREADY : if3.PREADY;
    endfunction

    function automatic logic get_err(input int which);
        return (which == 0) ? if0.PSLVERR : if3.PSLVERR;
    endfunction

    function automatic logic [31:0] get_rdata(input int which);
        return (which == 0) ? if0.PRDATA : if3.PRDATA;
    endfunction

    // Full APB transfer, started #1 after a rising edge; ends #1 after the completion edge.
    task automatic apb_xfer(input int which, input logic wr, input logic [12:0] addr,
                            input logic [31:0] data, output logic [31:0] rdata,
                            output logic err, output int waits);
        bit done;
        rdata = 32'd0;
        err   = 1'b0;
        waits = 0;
        done  = 1'b0;
        if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge PCLK); #1;
        penable = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge PCLK);
            if (get_ready(which)) begin
                rdata = get_rdata(which);
                err   = get_err(which);
                done  = 1'b1;
            end else begin
                waits++;
                @(posedge PCLK); #1;
            end
        end
        if (!done) chk("xfer_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic do_write(input int which, input logic [12:0] addr, input logic [31:0] data,
                            input logic exp_err);
        apb_xfer(which, 1'b1, addr, data, rd_v, err_v, waits_v);
        chk("wr_err", {31'd0, err_v}, {31'd0, exp_err});
        chk("wr_waits", 32'(waits_v), (which == 0) ? 32'd0 : 32'd3);
    endtask

    task automatic do_read(input int which, input logic [12:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
        apb_xfer(which, 1'b0, addr, 32'd0, rd_v, err_v, waits_v);
        chk("rd_data", rd_v, exp_data);
        chk("rd_err", {31'd0, err_v}, {31'd0, exp_err});
        chk("rd_waits", 32'(waits_v), (which == 0) ? 32'd0 : 32'd3);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        PRESETn  = 1'b0;
        psel0    = 1'b0;
        psel3    = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 13'd0;
        pwdata   = 32'd0;
`ifdef APB_MEM_SLAVE_PSTRB_EN
        pstrb    = 4'hF;
`endif

        // Reset held for 3 cycles: all outputs low.
        repeat (3) begin
            @(negedge PCLK);
            chk("rst_pready0",  {31'd0, if0.PREADY},  32'd0);
            chk("rst_pslverr0", {31'd0, if0.PSLVERR}, 32'd0);
            chk("rst_prdata0",  if0.PRDATA,           32'd0);
            chk("rst_pready3",  {31'd0, if3.PREADY},  32'd0);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Zero-wait write/read.
        do_write(0, 13'h010, 32'hDEADBEEF, 1'b0);
        do_read (0, 13'h010, 32'hDEADBEEF, 1'b0);
        @(negedge PCLK);
        chk("prdata_hold", if0.PRDATA, 32'hDEADBEEF);
        chk("pready_one_cycle", {31'd0, if0.PREADY}, 32'd0);
        @(posedge PCLK); #1;

        // Byte-lane placement: lowest address holds the MSB byte.
        do_write(0, 13'h040, 32'h01020304, 1'b0);
        chk("lane0", {24'd0, u_dut0.mem_r[8'h40]}, 32'h01);
        chk("lane1", {24'd0, u_dut0.mem_r[8'h41]}, 32'h02);
        chk("lane2", {24'd0, u_dut0.mem_r[8'h42]}, 32'h03);
        chk("lane3", {24'd0, u_dut0.mem_r[8'h43]}, 32'h04);
        do_read(0, 13'h040, 32'h01020304, 1'b0);

        // Three wait states: PREADY low for 3 access cycles, high on the 4th.
        apb_xfer(3, 1'b0, 13'h000, 32'd0, rd_v, err_v, waits_v);
        chk("ws3_waits", 32'(waits_v), 32'd3);
        chk("ws3_err", {31'd0, err_v}, 32'd0);

        // Sweep all 64 words on the wait-state instance.
        for (int i = 0; i < 64; i++) begin
            sweep_d[i] = $urandom();
            do_write(3, 13'(i * 4), sweep_d[i], 1'b0);
        end
        for (int i = 0; i < 64; i++) begin
            do_read(3, 13'(i * 4), sweep_d[i], 1'b0);
        end

        // Error cases.
        do_write(0, 13'h014, 32'h55667788, 1'b0);
        do_write(0, 13'h102, 32'hCAFEF00D, 1'b1);
        @(negedge PCLK);
        chk("pslverr_clear", {31'd0, if0.PSLVERR}, 32'd0);
        @(posedge PCLK); #1;
        do_write(0, 13'h012, 32'hCAFEF00D, 1'b1);
        do_read (0, 13'h010, 32'hDEADBEEF, 1'b0);
        do_read (0, 13'h014, 32'h55667788, 1'b0);
        do_read (0, 13'h100, 32'h00000000, 1'b1);
        do_write(0, 13'h0FC, 32'h0BADF00D, 1'b0);
        do_read (0, 13'h0FC, 32'h0BADF00D, 1'b0);
        do_read (0, 13'h0FD, 32'h00000000, 1'b1);
        do_read (3, 13'h100, 32'h00000000, 1'b1);

        // Abort: PSEL dropped during WAIT on a write.
        do_write(3, 13'h020, 32'h12345678, 1'b0);
        psel3 = 1'b1; pwrite = 1'b1; paddr = 13'h020; pwdata = 32'hFFFFFFFF; penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        chk("abort_wait", {31'd0, if3.PREADY}, 32'd0);
        @(posedge PCLK); #1;
        psel3 = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            chk("abort_idle", {31'd0, if3.PREADY}, 32'd0);
        end
        @(posedge PCLK); #1;
        do_read(3, 13'h020, 32'h12345678, 1'b0);

        // Reset while PREADY is high on a write: outputs clear at once, no write.
        do_read(0, 13'h010, 32'hDEADBEEF, 1'b0);
        psel0 = 1'b1; pwrite = 1'b1; paddr = 13'h010; pwdata = 32'hBADC0DE5; penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        chk("rstrdy_pre", {31'd0, if0.PREADY}, 32'd1);
        #1 PRESETn = 1'b0;
        #1;
        chk("rstrdy_pready", {31'd0, if0.PREADY}, 32'd0);
        chk("rstrdy_prdata", if0.PRDATA, 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        do_read(0, 13'h010, 32'hDEADBEEF, 1'b0);

        // Reset during WAIT; after release the orphan access phase is ignored.
        psel3 = 1'b1; pwrite = 1'b0; paddr = 13'h000; penable = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        chk("rstwait_pre", {31'd0, if3.PREADY}, 32'd0);
        #1 PRESETn = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            chk("rstwait_low", {31'd0, if3.PREADY}, 32'd0);
        end
        PRESETn = 1'b1;
        repeat (6) begin
            @(negedge PCLK);
            chk("rstwait_lost", {31'd0, if3.PREADY}, 32'd0);
        end
        @(posedge PCLK); #1;
        psel3 = 1'b0; penable = 1'b0;
        do_read(3, 13'h020, 32'h12345678, 1'b0);

`ifdef APB_MEM_SLAVE_PSTRB_EN
        // Lane strobes: lanes 0 and 2 (MSB byte and third byte) updated only.
        pstrb = 4'hF;
        do_write(0, 13'h030, 32'h11223344, 1'b0);
        pstrb = 4'b0101;
        do_write(0, 13'h030, 32'hAABBCCDD, 1'b0);
        pstrb = 4'b0000;
        do_write(0, 13'h030, 32'h99999999, 1'b0);
        pstrb = 4'b1010;
        do_read(0, 13'h030, 32'hAA22CC44, 1'b0);
        pstrb = 4'hF;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
